cu_program_sequencer: RTL and testbench
=======================================

Name: cu_program_sequencer

Overview:
- Sequences the 8-bit compute unit, which takes 16-bit instructions and has 1-cycle result latency.
- Host loads a short program byte-serially into a local instruction buffer, then starts it.
- Block issues one instruction per cycle to the compute unit, optionally repeats the whole program, returns each result with a tag, and signals completion.
- Sits between the top-level pin interface and the compute unit.

Parameters:
- DEPTH, 8, instruction buffer entries (power of two, ≥2).
- AW, 3, log2(DEPTH); PC/tag width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host byte write strobe.
- wr_byte  in  8  instruction byte; high byte first, then low byte.
- wr_ready  out  1  byte accepted when wr_valid & wr_ready.
- clear  in  1  discard program (IDLE only).
- start  in  1  run program (IDLE only).
- abort  in  1  stop issuing (ISSUE only).
- loop_count  in  4  extra iterations; total passes = loop_count+1; sampled at start.
- instr_out  out  16  instruction to compute unit; 16'h0000 when not issuing.
- cu_ena  out  1  compute unit enable; high only on issue cycles.
- cu_result  in  8  compute unit registered result output.
- result_valid  out  1  result_data/result_tag valid this cycle.
- result_data  out  8  captured compute unit result.
- result_tag  out  AW  buffer index of the instruction that produced result_data.
- prog_len  out  AW+1  committed instruction count, 0..DEPTH.
- busy  out  1  state is ISSUE or DRAIN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state=IDLE, prog_len=0, byte phase=high, pc=0, iter=0, result_valid=0, result_data=0, result_tag=0, done=0, issued_d=0. cu_ena=0 and instr_out=0 follow from IDLE.
- Reset mid-operation returns to IDLE immediately and drops any in-flight result. Buffer contents need not be cleared.
- States: IDLE, ISSUE, DRAIN (2 cycles, counter), DONE.
- wr_ready = (state==IDLE) & (prog_len<DEPTH).
- Loading, high byte: latch into hold register; phase toggles to low.
- Loading, low byte: write {hold, wr_byte} into buf[prog_len]; prog_len+1; phase returns to high.
- clear in IDLE: prog_len=0, phase=high. clear takes priority over a same-cycle write and over start. clear outside IDLE is ignored.
- Full buffer: wr_ready=0; further bytes are not accepted.
- start in IDLE with prog_len>0:
  - Pending high byte is discarded; phase=high.
  - pc=0, iter=0, loop_count latched; next state ISSUE.
- start with prog_len=0: go directly to DONE (done pulse next cycle, nothing issued).
- ISSUE, combinational outputs:
  - cu_ena = ~abort.
  - instr_out = abort ? 0 : buf[pc].
- ISSUE, next-state, abort=1: no issue this cycle; next state DRAIN.
- ISSUE, next-state, pc==prog_len-1 and iter<latched loop_count: pc=0, iter+1 (wrap into next pass, no bubble).
- ISSUE, next-state, pc==prog_len-1 and iter==loop_count: next state DRAIN.
- ISSUE, next-state, otherwise: pc+1.
- Result path:
  - issued_d <= cu_ena; tag_d <= pc.
  - On the cycle after issued_d=1: result_valid=1, result_data <= cu_result, result_tag <= tag_d. Otherwise result_valid=0.
  - Result for an instruction issued in cycle k appears on result_* in cycle k+2.
- DRAIN: exactly 2 cycles; cu_ena=0; then DONE.
- DONE: done=1 for one cycle, then IDLE. Program is retained, so start may rerun it.
- Timing, no abort (start sampled at T, N=prog_len, L=loop_count):
  - Issues occupy T+1 .. I, with I = T+N(L+1).
  - Last result_valid at I+2.
  - busy high T+1 .. I+2.
  - done at I+3.
- Timing, abort sampled at cycle A: results of issues before A still emerge; done at A+3.
- Ignored inputs: start/clear/wr_valid outside IDLE; abort outside ISSUE.
- Widths: prog_len AW+1 bits; pc and tag wrap only via the explicit rule above.

Test Plan:
- Load 9105, 9203, A312 (6 bytes); start at T with loop_count=0.
  - Expect instr_out 9105/9203/A312 at T+1..T+3.
  - Expect results 05/03/08 with tags 0/1/2 at T+3..T+5.
  - Expect done at T+6; prog_len=3.
- Same program, loop_count=2.
  - Expect 9 consecutive issues, tag sequence 0,1,2 ×3, done at T+12.
  - A312 accumulates: results 08, 10, 18.
- Fill all 8 entries.
  - Expect wr_ready=0 and prog_len=8; a 9th byte is not accepted.
  - clear → prog_len=0, wr_ready=1.
- Write one byte 0x91, then start with prog_len=2.
  - Expect the partial byte discarded; a next write 0x92,0x07 commits entry 2 only after the run.
- Abort at the 2nd issue cycle of a 3-instruction program.
  - Expect exactly 1 cu_ena pulse, 1 result_valid, done 3 cycles after abort.
- Reset asserted during ISSUE.
  - Next cycle expect cu_ena=0, result_valid=0, busy=0, prog_len=0.
  - start with an empty program → done pulse one cycle later, no cu_ena.

Source files
------------

// File: rtl/cu_program_sequencer.sv
// cu_program_sequencer: holds a short program loaded byte-serially by the
// host and issues it one instruction per cycle to the compute unit,
// optionally repeating it, then returns each result tagged with the buffer
// index of the instruction that produced it.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_valid/wr_byte   host byte write (high byte first); wr_ready accepts
//   clear, start       discard / run program (IDLE only)
//   abort              stop issuing (ISSUE only)
//   loop_count         extra passes, sampled at start
//   instr_out, cu_ena  instruction and enable to the compute unit
//   cu_result          compute unit registered result
//   result_valid/data/tag  captured result and its buffer index
//   prog_len           committed instruction count
//   busy, done         running flag, one-cycle completion pulse
module cu_program_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [7:0]    wr_byte,
  output logic          wr_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    loop_count,
  output logic [15:0]   instr_out,
  output logic          cu_ena,
  input  logic [7:0]    cu_result,
  output logic          result_valid,
  output logic [7:0]    result_data,
  output logic [AW-1:0] result_tag,
  output logic [AW:0]   prog_len,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [15:0]   mem [DEPTH];
  logic [7:0]    hold;
  logic          phase_lo;
  logic [AW-1:0] pc;
  logic [3:0]    iter;
  logic [3:0]    loop_lat;
  logic          drain_cnt;
  logic          issued_d;
  logic [AW-1:0] tag_d;
  logic          last_instr;
  logic          wr_fire;

  assign last_instr = ((AW+1)'(pc) == (prog_len - (AW+1)'(1)));
  // clear and start both pre-empt a same-cycle byte write
  assign wr_fire    = (state == S_IDLE) && wr_valid && wr_ready && !clear && !start;

  // Next-state and combinational compute-unit drive
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    cu_ena     = 1'b0;
    instr_out  = 16'h0000;
    case (state)
      S_IDLE: begin
        wr_ready = (prog_len < (AW+1)'(DEPTH));
        if (!clear && start)
          state_next = (prog_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        cu_ena    = ~abort;
        instr_out = abort ? 16'h0000 : mem[pc];
        if (abort || (last_instr && (iter == loop_lat)))
          state_next = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, load control, program counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      prog_len     <= '0;
      phase_lo     <= 1'b0;
      hold         <= 8'h00;
      pc           <= '0;
      iter         <= 4'd0;
      loop_lat     <= 4'd0;
      drain_cnt    <= 1'b0;
      issued_d     <= 1'b0;
      tag_d        <= '0;
      result_valid <= 1'b0;
      result_data  <= 8'h00;
      result_tag   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      busy         <= (state_next == S_ISSUE) || (state_next == S_DRAIN);
      done         <= (state_next == S_DONE);
      drain_cnt    <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      // CU result registers one cycle after issue; capture it the cycle after
      issued_d     <= cu_ena;
      tag_d        <= pc;
      result_valid <= issued_d;
      if (issued_d) begin
        result_data <= cu_result;
        result_tag  <= tag_d;
      end
      case (state)
        S_IDLE: begin
          if (clear) begin
            prog_len <= '0;
            phase_lo <= 1'b0;
          end else if (start) begin
            phase_lo <= 1'b0;   // a dangling high byte is dropped
            pc       <= '0;
            iter     <= 4'd0;
            loop_lat <= loop_count;
          end else if (wr_fire) begin
            if (!phase_lo) hold <= wr_byte;
            else           prog_len <= prog_len + (AW+1)'(1);
            phase_lo <= ~phase_lo;
          end
        end
        S_ISSUE: begin
          if (!abort) begin
            if (!last_instr) begin
              pc <= pc + AW'(1);
            end else if (iter != loop_lat) begin
              pc   <= '0;
              iter <= iter + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction buffer; contents survive reset and clear
  always_ff @(posedge clk) begin
    if (!rst && wr_fire && phase_lo)
      mem[prog_len[AW-1:0]] <= {hold, wr_byte};
  end

endmodule

// File: tb/tb_cu_program_sequencer.sv
// Bench for cu_program_sequencer: a table of per-cycle vectors for the basic
// load/run, hand sequences for looping, full buffer, partial byte, abort and
// reset, and a tag/data scoreboard fed by a small compute-unit model.
module tb_cu_program_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [7:0]    wr_byte;
  logic          wr_ready;
  logic          clear;
  logic          start;
  logic          abort;
  logic [3:0]    loop_count;
  logic [15:0]   instr_out;
  logic          cu_ena;
  logic [7:0]    cu_result;
  logic          result_valid;
  logic [7:0]    result_data;
  logic [AW-1:0] result_tag;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  cu_program_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_byte(wr_byte),
    .wr_ready(wr_ready), .clear(clear), .start(start), .abort(abort),
    .loop_count(loop_count), .instr_out(instr_out), .cu_ena(cu_ena),
    .cu_result(cu_result), .result_valid(result_valid),
    .result_data(result_data), .result_tag(result_tag),
    .prog_len(prog_len), .busy(busy), .done(done)
  );

  // Compute unit: 9dii loads imm into r[d]; Adst accumulates r[d]+=r[s]+r[t]
  function automatic logic [7:0] alu(input logic [15:0] ins, input logic [7:0] rd,
                                     input logic [7:0] rs, input logic [7:0] rt);
    case (ins[15:12])
      4'h9:    return ins[7:0];
      4'hA:    return 8'(rd + rs + rt);
      default: return 8'h00;
    endcase
  endfunction

  logic       cu_clr;
  logic [7:0] cu_r [16];

  always @(posedge clk) begin
    if (cu_clr) begin
      for (int i = 0; i < 16; i++) cu_r[i] <= 8'h00;
      cu_result <= 8'h00;
    end else if (cu_ena) begin
      cu_result <= alu(instr_out, cu_r[instr_out[11:8]], cu_r[instr_out[7:4]], cu_r[instr_out[3:0]]);
      if (instr_out[15:12] == 4'h9 || instr_out[15:12] == 4'hA)
        cu_r[instr_out[11:8]] <= alu(instr_out, cu_r[instr_out[11:8]], cu_r[instr_out[7:4]], cu_r[instr_out[3:0]]);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] tag;
    logic [7:0] data;
  } sb_t;

  typedef struct packed {
    logic        wv;
    logic [7:0]  wb;
    logic        st;
    logic [3:0]  lc;
    logic        rdy;
    logic        ena;
    logic [15:0] ins;
    logic        rv;
    logic [7:0]  dat;
    logic [2:0]  tag;
    logic [3:0]  len;
    logic        bsy;
    logic        dn;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  sb_t         q [$];
  logic [7:0]  ref_r [16];
  logic [15:0] sb_prog [8];
  int          sb_n, sb_idx;
  int          n_issue, n_rv, n_done, done_cyc, first_issue;
  vec_t        tbl [14];

  function automatic vec_t mk(input logic wv, input logic [7:0] wb, input logic st,
                              input logic [3:0] lc, input logic rdy, input logic ena,
                              input logic [15:0] ins, input logic rv, input logic [7:0] dat,
                              input logic [2:0] tag, input logic [3:0] len,
                              input logic bsy, input logic dn);
    vec_t v;
    v.wv = wv; v.wb = wb; v.st = st; v.lc = lc; v.rdy = rdy; v.ena = ena;
    v.ins = ins; v.rv = rv; v.dat = dat; v.tag = tag; v.len = len; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle observation: scoreboard push on issue, pop on result
  task automatic sample();
    logic [2:0]  tag;
    logic [15:0] ins;
    logic [7:0]  v;
    sb_t         e;
    if (cu_ena) begin
      n_issue++;
      if (n_issue == 1) first_issue = cyc;
      if (sb_n == 0) begin
        chk("unexpected_issue", 64'(cu_ena), 64'(0));
      end else begin
        tag = 3'(sb_idx % sb_n);
        ins = sb_prog[tag];
        chk("instr_out", 64'(instr_out), 64'(ins));
        v = alu(ins, ref_r[ins[11:8]], ref_r[ins[7:4]], ref_r[ins[3:0]]);
        if (ins[15:12] == 4'h9 || ins[15:12] == 4'hA) ref_r[ins[11:8]] = v;
        e.tag = tag;
        e.data = v;
        q.push_back(e);
        sb_idx++;
      end
    end
    if (result_valid) begin
      n_rv++;
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(result_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("result_tag", 64'(result_tag), 64'(e.tag));
        chk("result_data", 64'(result_data), 64'(e.data));
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic finish_cycle();
    sample();
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    finish_cycle();
  endtask

  task automatic mon_clear();
    n_issue = 0; n_rv = 0; n_done = 0; done_cyc = -1; first_issue = -1;
    sb_idx = 0;
    q.delete();
  endtask

  task automatic cu_reset();
    cu_clr = 1'b1;
    for (int i = 0; i < 16; i++) ref_r[i] = 8'h00;
    step();
    cu_clr = 1'b0;
  endtask

  task automatic set_prog(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input int n);
    sb_prog[0] = a; sb_prog[1] = b; sb_prog[2] = c; sb_n = n;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_byte  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && n_done == 0; k++) step();
  endtask

  // Start, run to the done pulse, then check timing and counts
  task automatic run_prog(input logic [3:0] lc, input int exp_issues, input int exp_done);
    int t;
    mon_clear();
    t = cyc;
    start = 1'b1;
    loop_count = lc;
    step();
    start = 1'b0;
    wait_done(40);
    chk("done_seen", 64'(n_done), 64'(1));
    chk("done_cycle", 64'(done_cyc - t), 64'(exp_done));
    chk("issue_count", 64'(n_issue), 64'(exp_issues));
    chk("result_count", 64'(n_rv), 64'(exp_issues));
    if (exp_issues > 0) chk("first_issue", 64'(first_issue - t), 64'(1));
    chk("sb_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    logic [35:0] act, exp;
    int t;
    rst = 1'b1; wr_valid = 1'b0; wr_byte = 8'h00; clear = 1'b0; start = 1'b0;
    abort = 1'b0; loop_count = 4'd0; cu_clr = 1'b1;
    sb_n = 0;
    for (int i = 0; i < 16; i++) ref_r[i] = 8'h00;
    mon_clear();

    tbl[0]  = mk(1'b1, 8'h91, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h05, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 8'h92, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 8'h03, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 8'hA3, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd2, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 8'h12, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd2, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd3, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 16'h9105, 1'b0, 8'h00, 3'd0, 4'd3, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 16'h9203, 1'b0, 8'h00, 3'd0, 4'd3, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 16'hA312, 1'b1, 8'h05, 3'd0, 4'd3, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h03, 3'd1, 4'd3, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h08, 3'd2, 4'd3, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd3, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 3'd0, 4'd3, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cu_clr = 1'b0;
    #1;
    chk("rst_prog_len", 64'(prog_len), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("rst_outputs", 64'({cu_ena, instr_out, result_valid, busy, done}), 64'(0));
    finish_cycle();

    // Basic load and single pass, one vector per cycle
    set_prog(16'h9105, 16'h9203, 16'hA312, 3);
    mon_clear();
    for (int i = 0; i < 14; i++) begin
      wr_valid = tbl[i].wv;
      wr_byte = tbl[i].wb;
      start = tbl[i].st;
      loop_count = tbl[i].lc;
      #1;
      act = {wr_ready, cu_ena, instr_out, result_valid,
             tbl[i].rv ? result_data : 8'h00, tbl[i].rv ? result_tag : 3'd0,
             prog_len, busy, done};
      exp = {tbl[i].rdy, tbl[i].ena, tbl[i].ins, tbl[i].rv, tbl[i].dat, tbl[i].tag,
             tbl[i].len, tbl[i].bsy, tbl[i].dn};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
      finish_cycle();
    end
    wr_valid = 1'b0;
    start = 1'b0;
    chk("vec_sb_empty", 64'(q.size()), 64'(0));

    // Three passes back to back; A312 accumulates 08, 10, 18
    cu_reset();
    run_prog(4'd2, 9, 12);
    chk("loop_last_issue_r3", 64'(ref_r[3]), 64'(8'h18));

    // Fill the buffer; a ninth entry's byte is refused
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) wr((i % 2 == 0) ? 8'h91 : 8'(i));
    #1;
    chk("full_wr_ready", 64'(wr_ready), 64'(0));
    chk("full_prog_len", 64'(prog_len), 64'(8));
    finish_cycle();
    wr(8'h55);
    wr(8'h66);
    chk("full_no_accept", 64'(prog_len), 64'(8));
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("clear_prog_len", 64'(prog_len), 64'(0));
    chk("clear_wr_ready", 64'(wr_ready), 64'(1));
    finish_cycle();

    // Dangling high byte is discarded at start
    wr(8'h91); wr(8'h05); wr(8'h92); wr(8'h03);
    wr(8'h91);
    chk("partial_len", 64'(prog_len), 64'(2));
    set_prog(16'h9105, 16'h9203, 16'h0000, 2);
    run_prog(4'd0, 2, 5);
    wr(8'h92);
    chk("partial_dropped", 64'(prog_len), 64'(2));
    wr(8'h07);
    chk("partial_commit", 64'(prog_len), 64'(3));
    set_prog(16'h9105, 16'h9203, 16'h9207, 3);
    run_prog(4'd0, 3, 6);

    // Abort on the second issue cycle
    mon_clear();
    t = cyc;
    start = 1'b1;
    loop_count = 4'd0;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    #1;
    chk("abort_cu_ena", 64'(cu_ena), 64'(0));
    chk("abort_instr", 64'(instr_out), 64'(0));
    finish_cycle();
    abort = 1'b0;
    wait_done(20);
    chk("abort_done_cycle", 64'(done_cyc - t), 64'(5));
    chk("abort_issues", 64'(n_issue), 64'(1));
    chk("abort_results", 64'(n_rv), 64'(1));

    // Reset during ISSUE drops everything in flight
    mon_clear();
    start = 1'b1;
    loop_count = 4'd3;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_outputs", 64'({cu_ena, result_valid, busy, done}), 64'(0));
    chk("midrst_prog_len", 64'(prog_len), 64'(0));
    finish_cycle();
    step();
    step();

    // Empty program completes immediately
    set_prog(16'h0000, 16'h0000, 16'h0000, 0);
    run_prog(4'd0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
